// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - SPI slave, LSB-first WIDTH-bit frames, all four CPOL/CPHA modes.
// SCLK/SS_N/MOSI are oversampled through synchronizers, then edge-detected one cycle later.
module spi_slave #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             CPOL_IN,
  input  logic             CPHA_IN,
  input  logic             SCLK,
  input  logic             SS_N,
  input  logic             MOSI,
  output logic             MISO,
  output logic             MISO_OE,
  input  logic [WIDTH-1:0] TX_DATA,
  input  logic             TX_LOAD,
  output logic             TX_READY,
  output logic [WIDTH-1:0] RX_DATA,
  output logic             RX_VALID,
  output logic             FRAME_ACTIVE,
  output logic             UNDERRUN,
  output logic             FRAME_ERR
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_DONE
  } state_t;

  // Top two taps of the SCLK/SS_N chains are the current and previous synchronized levels.
  logic [SYNC_STAGES+1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES+1:0] ss_sync_q,   ss_sync_d;
  logic [SYNC_STAGES:0]   mosi_sync_q, mosi_sync_d;

  state_t           state_q, state_d;
  logic             cpol_q, cpol_d;
  logic             cpha_q, cpha_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sampled_q, sampled_d;
  logic [WIDTH-1:0] tx_buf_q, tx_buf_d;
  logic             tx_ready_q, tx_ready_d;
  logic             miso_q, miso_d;
  logic             miso_oe_q, miso_oe_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             frame_active_q, frame_active_d;
  logic             underrun_q, underrun_d;
  logic             frame_err_q, frame_err_d;

  logic             sclk_cur, sclk_prev, ss_cur, ss_prev, mosi_s;
  logic             ss_fall, ss_rise, sclk_edge, leading, trailing;
  logic             sample_edge, shift_edge;
  logic [WIDTH-1:0] shift_in;

  assign sclk_cur  = sclk_sync_q[SYNC_STAGES];
  assign sclk_prev = sclk_sync_q[SYNC_STAGES+1];
  assign ss_cur    = ss_sync_q[SYNC_STAGES];
  assign ss_prev   = ss_sync_q[SYNC_STAGES+1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES];

  assign ss_fall     = ss_prev & ~ss_cur;
  assign ss_rise     = ~ss_prev & ss_cur;
  assign sclk_edge   = sclk_cur ^ sclk_prev;
  assign leading     = sclk_edge & (sclk_cur != cpol_q);
  assign trailing    = sclk_edge & (sclk_cur == cpol_q);
  assign sample_edge = cpha_q ? trailing : leading;
  assign shift_edge  = cpha_q ? leading : trailing;
  assign shift_in    = {mosi_s, shift_q[WIDTH-1:1]};

  always_comb begin
    sclk_sync_d    = {sclk_sync_q[SYNC_STAGES:0], SCLK};
    ss_sync_d      = {ss_sync_q[SYNC_STAGES:0], SS_N};
    mosi_sync_d    = {mosi_sync_q[SYNC_STAGES-1:0], MOSI};
    state_d        = state_q;
    cpol_d         = cpol_q;
    cpha_d         = cpha_q;
    shift_d        = shift_q;
    cnt_d          = cnt_q;
    sampled_d      = sampled_q;
    tx_buf_d       = tx_buf_q;
    tx_ready_d     = tx_ready_q;
    miso_d         = miso_q;
    miso_oe_d      = miso_oe_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = 1'b0;
    frame_active_d = frame_active_q;
    underrun_d     = 1'b0;
    frame_err_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (ss_fall) begin
          state_d        = S_ACTIVE;
          cpol_d         = CPOL_IN;
          cpha_d         = CPHA_IN;
          shift_d        = tx_ready_q ? '0 : tx_buf_q;
          miso_d         = tx_ready_q ? 1'b0 : tx_buf_q[0];
          underrun_d     = tx_ready_q;
          tx_ready_d     = 1'b1;
          miso_oe_d      = 1'b1;
          frame_active_d = 1'b1;
          cnt_d          = '0;
          sampled_d      = 1'b0;
        end
      end
      S_ACTIVE: begin
        // A deselect wins over any SCLK edge seen in the same cycle.
        if (ss_rise) begin
          state_d        = S_IDLE;
          frame_err_d    = 1'b1;
          miso_d         = 1'b0;
          miso_oe_d      = 1'b0;
          frame_active_d = 1'b0;
        end else if (sample_edge) begin
          shift_d   = shift_in;
          cnt_d     = cnt_q + CW'(1);
          sampled_d = 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_d    = S_DONE;
            rx_data_d  = shift_in;
            rx_valid_d = 1'b1;
            miso_d     = 1'b0;
          end
        end else if (shift_edge && sampled_q) begin
          miso_d    = shift_q[0];
          sampled_d = 1'b0;
        end
      end
      S_DONE: begin
        if (ss_rise) begin
          state_d        = S_IDLE;
          miso_d         = 1'b0;
          miso_oe_d      = 1'b0;
          frame_active_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Applied last so a load in the frame-start cycle stays buffered for the next frame.
    if (TX_LOAD) begin
      tx_buf_d   = TX_DATA;
      tx_ready_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      // SS_N chain resets to "selected" so a select held through reset never starts a frame.
      sclk_sync_q    <= '0;
      ss_sync_q      <= '0;
      mosi_sync_q    <= '0;
      state_q        <= S_IDLE;
      cpol_q         <= 1'b0;
      cpha_q         <= 1'b0;
      shift_q        <= '0;
      cnt_q          <= '0;
      sampled_q      <= 1'b0;
      tx_buf_q       <= '0;
      tx_ready_q     <= 1'b1;
      miso_q         <= 1'b0;
      miso_oe_q      <= 1'b0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      frame_active_q <= 1'b0;
      underrun_q     <= 1'b0;
      frame_err_q    <= 1'b0;
    end else begin
      sclk_sync_q    <= sclk_sync_d;
      ss_sync_q      <= ss_sync_d;
      mosi_sync_q    <= mosi_sync_d;
      state_q        <= state_d;
      cpol_q         <= cpol_d;
      cpha_q         <= cpha_d;
      shift_q        <= shift_d;
      cnt_q          <= cnt_d;
      sampled_q      <= sampled_d;
      tx_buf_q       <= tx_buf_d;
      tx_ready_q     <= tx_ready_d;
      miso_q         <= miso_d;
      miso_oe_q      <= miso_oe_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      frame_active_q <= frame_active_d;
      underrun_q     <= underrun_d;
      frame_err_q    <= frame_err_d;
    end
  end

  assign MISO         = miso_q;
  assign MISO_OE      = miso_oe_q;
  assign TX_READY     = tx_ready_q;
  assign RX_DATA      = rx_data_q;
  assign RX_VALID     = rx_valid_q;
  assign FRAME_ACTIVE = frame_active_q;
  assign UNDERRUN     = underrun_q;
  assign FRAME_ERR    = frame_err_q;

endmodule

// File: tb/tb_spi_slave.sv
// tb/tb_spi_slave.sv - randomized SPI master driving spi_slave against a frame-level model.
module tb_spi_slave;

  localparam int SYNC = 2;
  localparam int HALF = 8;

  logic       CLK, RST_N, CPOL_IN, CPHA_IN, SCLK, SS_N, MOSI;
  logic       MISO, MISO_OE, TX_LOAD, TX_READY, RX_VALID;
  logic       FRAME_ACTIVE, UNDERRUN, FRAME_ERR;
  logic [7:0] TX_DATA, RX_DATA;

  spi_slave #(.WIDTH(8), .SYNC_STAGES(SYNC)) dut (
    .CLK(CLK), .RST_N(RST_N), .CPOL_IN(CPOL_IN), .CPHA_IN(CPHA_IN),
    .SCLK(SCLK), .SS_N(SS_N), .MOSI(MOSI), .MISO(MISO), .MISO_OE(MISO_OE),
    .TX_DATA(TX_DATA), .TX_LOAD(TX_LOAD), .TX_READY(TX_READY),
    .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .FRAME_ACTIVE(FRAME_ACTIVE),
    .UNDERRUN(UNDERRUN), .FRAME_ERR(FRAME_ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  // Pulse monitors: event counts plus any pulse wider than one cycle.
  int   rv_cnt = 0, ur_cnt = 0, fe_cnt = 0, wide_cnt = 0;
  logic rv_prev = 1'b0, ur_prev = 1'b0, fe_prev = 1'b0;
  always @(negedge CLK) begin
    rv_cnt   <= rv_cnt + int'(RX_VALID);
    ur_cnt   <= ur_cnt + int'(UNDERRUN);
    fe_cnt   <= fe_cnt + int'(FRAME_ERR);
    wide_cnt <= wide_cnt + int'(RX_VALID & rv_prev) + int'(UNDERRUN & ur_prev)
                + int'(FRAME_ERR & fe_prev);
    rv_prev  <= RX_VALID;
    ur_prev  <= UNDERRUN;
    fe_prev  <= FRAME_ERR;
  end

  // Reference model: TX buffer contents/empty flag and last received word.
  logic [7:0] m_buf;
  logic       m_ready;
  logic [7:0] m_rx;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic load_tx(input logic [7:0] d);
    @(negedge CLK);
    TX_DATA = d;
    TX_LOAD = 1'b1;
    @(negedge CLK);
    TX_LOAD = 1'b0;
    m_buf   = d;
    m_ready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_miso"}, MISO, 0);
    check_eq({tag, "_miso_oe"}, MISO_OE, 0);
    check_eq({tag, "_rx_data"}, RX_DATA, 0);
    check_eq({tag, "_rx_valid"}, RX_VALID, 0);
    check_eq({tag, "_tx_ready"}, TX_READY, 1);
    check_eq({tag, "_frame_active"}, FRAME_ACTIVE, 0);
    check_eq({tag, "_underrun"}, UNDERRUN, 0);
    check_eq({tag, "_frame_err"}, FRAME_ERR, 0);
  endtask

  // One select period of ncyc SCLK cycles; fewer than 8 cycles is an aborted frame.
  task automatic do_frame(input string tag, input logic cpol, input logic cpha,
                          input logic [7:0] mw, input int ncyc,
                          input bit collide, input logic [7:0] cw);
    logic [15:0] mv, got_m, exp_m;
    logic [7:0]  word, ext;
    logic        und;
    bit          complete;
    int          rv0, ur0, fe0;

    ext      = 8'($urandom);
    mv       = {ext, mw};
    complete = (ncyc >= 8);
    got_m    = '0;
    exp_m    = '0;

    CPOL_IN = cpol;
    CPHA_IN = cpha;
    SCLK    = cpol;
    wait_clks(HALF);
    rv0 = rv_cnt; ur0 = ur_cnt; fe0 = fe_cnt;

    und     = m_ready;
    word    = m_ready ? 8'h00 : m_buf;
    m_ready = 1'b1;
    if (collide) begin
      m_buf   = cw;
      m_ready = 1'b0;
    end
    for (int i = 0; i < ncyc; i++) exp_m[i] = (i < 8) ? word[i] : 1'b0;

    SS_N = 1'b0;
    if (!cpha) MOSI = mv[0];
    if (collide) begin
      repeat (SYNC + 1) @(negedge CLK);
      TX_DATA = cw;
      TX_LOAD = 1'b1;
      @(negedge CLK);
      TX_LOAD = 1'b0;
      wait_clks(HALF - SYNC - 2);
    end else begin
      wait_clks(HALF);
    end
    check_eq({tag, "_active"}, {FRAME_ACTIVE, MISO_OE}, 2'b11);
    CPOL_IN = ~cpol;
    CPHA_IN = ~cpha;

    for (int i = 0; i < ncyc; i++) begin
      if (!cpha) got_m[i] = MISO;
      else       MOSI = mv[i];
      SCLK = ~cpol;
      wait_clks(HALF);
      if (cpha) got_m[i] = MISO;
      SCLK = cpol;
      if (!cpha) MOSI = mv[i+1];
      wait_clks(HALF);
    end

    SS_N = 1'b1;
    wait_clks(HALF);
    if (complete) m_rx = mw;

    check_eq({tag, "_miso_bits"}, got_m, exp_m);
    check_eq({tag, "_rx_data"}, RX_DATA, m_rx);
    check_eq({tag, "_rx_valid_n"}, rv_cnt - rv0, complete ? 1 : 0);
    check_eq({tag, "_frame_err_n"}, fe_cnt - fe0, complete ? 0 : 1);
    check_eq({tag, "_underrun_n"}, ur_cnt - ur0, und);
    check_eq({tag, "_deselect"}, {MISO_OE, FRAME_ACTIVE, MISO}, 3'b000);
    check_eq({tag, "_tx_ready"}, TX_READY, m_ready);
  endtask

  initial begin
    RST_N   = 1'b0;
    CPOL_IN = 1'b0;
    CPHA_IN = 1'b0;
    SCLK    = 1'b0;
    SS_N    = 1'b1;
    MOSI    = 1'b0;
    TX_DATA = 8'h00;
    TX_LOAD = 1'b0;
    m_buf   = 8'h00;
    m_ready = 1'b1;
    m_rx    = 8'h00;
    wait_clks(3);
    check_reset_outputs("in_reset");
    RST_N = 1'b1;
    wait_clks(6);
    check_reset_outputs("after_reset");

    // Mode 0 and modes 1-3
    load_tx(8'hA5);
    do_frame("mode0", 1'b0, 1'b0, 8'h3C, 8, 1'b0, 8'h00);
    load_tx(8'h5A);
    do_frame("mode1", 1'b0, 1'b1, 8'hC3, 8, 1'b0, 8'h00);
    load_tx(8'h5A);
    do_frame("mode2", 1'b1, 1'b0, 8'hC3, 8, 1'b0, 8'h00);
    load_tx(8'h5A);
    do_frame("mode3", 1'b1, 1'b1, 8'hC3, 8, 1'b0, 8'h00);

    do_frame("underrun", 1'b0, 1'b0, 8'hFF, 8, 1'b0, 8'h00);

    // Abort, then a frame that finds the consumed word gone
    load_tx(8'h96);
    do_frame("pre_abort", 1'b0, 1'b0, 8'h3C, 8, 1'b0, 8'h00);
    load_tx(8'h69);
    do_frame("abort", 1'b0, 1'b0, 8'hE7, 5, 1'b0, 8'h00);
    do_frame("post_abort", 1'b0, 1'b0, 8'h81, 8, 1'b0, 8'h00);

    // Collision of TX_LOAD with frame start
    load_tx(8'h22);
    do_frame("collide", 1'b0, 1'b0, 8'h4D, 8, 1'b1, 8'h11);
    do_frame("after_collide", 1'b0, 1'b1, 8'hB2, 8, 1'b0, 8'h00);

    load_tx(8'hC9);
    do_frame("extra_edges", 1'b0, 1'b0, 8'h17, 10, 1'b0, 8'h00);

    // Reset mid-frame after 3 bits
    load_tx(8'h5C);
    CPOL_IN = 1'b0;
    CPHA_IN = 1'b0;
    SCLK    = 1'b0;
    wait_clks(HALF);
    SS_N = 1'b0;
    wait_clks(HALF);
    for (int i = 0; i < 3; i++) begin
      MOSI = i[0];
      SCLK = 1'b1;
      wait_clks(HALF);
      SCLK = 1'b0;
      wait_clks(HALF);
    end
    RST_N = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    wait_clks(2);
    RST_N = 1'b1;
    m_buf   = 8'h00;
    m_ready = 1'b1;
    m_rx    = 8'h00;
    wait_clks(12);
    check_eq("held_select_no_frame", FRAME_ACTIVE, 0);
    SS_N = 1'b1;
    wait_clks(HALF);
    load_tx(8'h3E);
    do_frame("post_reset", 1'b1, 1'b0, 8'hD4, 8, 1'b0, 8'h00);

    // Randomized frames: mode, optional load, length (aborted/normal/extra edges)
    for (int k = 0; k < 16; k++) begin
      int   r, n;
      logic c0, c1;
      r  = int'($urandom_range(0, 7));
      n  = (r < 2) ? int'($urandom_range(1, 7)) : ((r == 2) ? int'($urandom_range(9, 11)) : 8);
      c0 = 1'($urandom);
      c1 = 1'($urandom);
      if ($urandom_range(0, 3) != 0) load_tx(8'($urandom));
      do_frame($sformatf("rand%0d", k), c0, c1, 8'($urandom), n, 1'b0, 8'h00);
    end

    check_eq("pulse_width", wide_cnt, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
